// File: rtl/shot_seq_pkg.sv
// Shared types and constants for the shot sequencer: FSM state encoding,
// default frame counts and the frame counter width.
package shot_seq_pkg;

    localparam int FRAME_CNT_W = 4;

    localparam int DEFAULT_BLANK_FRAMES    = 1;
    localparam int DEFAULT_TARGET_FRAMES   = 1;
    localparam int DEFAULT_COOLDOWN_FRAMES = 8;
    localparam int DEFAULT_SHOTS_PER_ROUND = 3;

    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_BLANK    = 3'd2,
        S_TARGET   = 3'd3,
        S_RESOLVE  = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw input through two flops so the second one is safe to use
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: accepts a trigger, spends ammunition and, for the light
// gun, runs the blank / target-box flash sequence while sampling the
// photodetector. Each accepted shot ends with exactly one hit or miss pulse.
// The input mode is captured by the branch taken out of IDLE (ARM for the
// gun, RESOLVE for the mouse), so later changes of gun_is_connected have
// no effect until the shot is back in IDLE.
module shot_sequencer
    import shot_seq_pkg::*;
#(
    parameter int BLANK_FRAMES    = DEFAULT_BLANK_FRAMES,
    parameter int TARGET_FRAMES   = DEFAULT_TARGET_FRAMES,
    parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES,
    parameter int SHOTS_PER_ROUND = DEFAULT_SHOTS_PER_ROUND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_start,
    input  logic       i_round_start,
    input  logic       i_gun_is_connected,
    input  logic       i_trigger_pulse,
    input  logic       i_gun_photodetector,
    input  logic       i_mouse_on_target,
    output logic       o_screen_black,
    output logic       o_draw_target_box,
    output logic       o_hit,
    output logic       o_miss,
    output logic [1:0] o_shots_left,
    output logic       o_out_of_ammo,
    output logic       o_busy
);

    localparam frame_cnt_t BLANK_LAST    = frame_cnt_t'(BLANK_FRAMES - 1);
    localparam frame_cnt_t TARGET_LAST   = frame_cnt_t'(TARGET_FRAMES - 1);
    localparam frame_cnt_t COOLDOWN_LAST = frame_cnt_t'(COOLDOWN_FRAMES - 1);
    localparam logic [1:0] SHOTS_LOAD    = 2'(SHOTS_PER_ROUND);

    state_t     r_state;
    state_t     w_next_state;
    frame_cnt_t r_frame_cnt;
    logic [1:0] r_shots_left;
    logic [1:0] w_shots_avail;
    logic       r_seen;
    logic       r_cheat;
    logic       w_pd_sync;
    logic       w_accept;
    logic       w_blank_done;
    logic       w_target_done;
    logic       w_cooldown_done;
    logic       w_screen_black;
    logic       w_draw_target_box;
    logic       w_hit;
    logic       w_miss;
    logic       r_screen_black;
    logic       r_draw_target_box;
    logic       r_hit;
    logic       r_miss;

    sync_2ff u_pd_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_gun_photodetector),
        .o_q (w_pd_sync)
    );

    // A reload in the same cycle as a trigger counts before the shot is taken
    assign w_shots_avail   = i_round_start ? SHOTS_LOAD : r_shots_left;
    assign w_accept        = (r_state == S_IDLE) && i_trigger_pulse && (w_shots_avail != 2'd0);
    assign w_blank_done    = i_frame_start && (r_frame_cnt == BLANK_LAST);
    assign w_target_done   = i_frame_start && (r_frame_cnt == TARGET_LAST);
    assign w_cooldown_done = i_frame_start && (r_frame_cnt == COOLDOWN_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: frame_start paces every step of the gun sequence
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = i_gun_is_connected ? S_ARM : S_RESOLVE;
                end
            end
            S_ARM: begin
                if (i_frame_start) begin
                    w_next_state = S_BLANK;
                end
            end
            S_BLANK: begin
                if (w_blank_done) begin
                    w_next_state = S_TARGET;
                end
            end
            S_TARGET: begin
                if (w_target_done) begin
                    w_next_state = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                w_next_state = (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (w_cooldown_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode; draw controls follow the state being entered so the
    // registered copies line up with the state change
    always_comb begin
        w_screen_black    = (w_next_state == S_BLANK) || (w_next_state == S_TARGET);
        w_draw_target_box = (w_next_state == S_TARGET);
        w_hit             = (r_state == S_RESOLVE) && r_seen && !r_cheat;
        w_miss            = (r_state == S_RESOLVE) && !(r_seen && !r_cheat);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_screen_black    <= 1'b0;
            r_draw_target_box <= 1'b0;
            r_hit             <= 1'b0;
            r_miss            <= 1'b0;
        end else begin
            r_screen_black    <= w_screen_black;
            r_draw_target_box <= w_draw_target_box;
            r_hit             <= w_hit;
            r_miss            <= w_miss;
        end
    end

    // Ammunition: reload on round_start, spend one per accepted trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shots_left <= 2'd0;
        end else if (w_accept) begin
            r_shots_left <= w_shots_avail - 2'd1;
        end else if (i_round_start) begin
            r_shots_left <= SHOTS_LOAD;
        end
    end

    // Frame counter: restarts on every state change, counts frame_starts within a state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_frame_cnt <= '0;
        end else if (i_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Seen/cheat flags: light during blank frames means the gun is aimed at a lamp
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen  <= 1'b0;
            r_cheat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_seen  <= i_gun_is_connected ? 1'b0 : i_mouse_on_target;
                        r_cheat <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (i_frame_start) begin
                        r_seen  <= 1'b0;
                        r_cheat <= 1'b0;
                    end
                end
                S_BLANK: begin
                    if (w_pd_sync) begin
                        r_cheat <= 1'b1;
                    end
                end
                S_TARGET: begin
                    if (w_pd_sync) begin
                        r_seen <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_screen_black    = r_screen_black;
    assign o_draw_target_box = r_draw_target_box;
    assign o_hit             = r_hit;
    assign o_miss            = r_miss;
    assign o_shots_left      = r_shots_left;
    assign o_out_of_ammo     = (r_shots_left == 2'd0);
    assign o_busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed testbench for shot_sequencer with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, i.e. they reflect the edge just taken.
module tb_shot_sequencer;

    logic       clk;
    logic       rst;
    logic       i_frame_start;
    logic       i_round_start;
    logic       i_gun_is_connected;
    logic       i_trigger_pulse;
    logic       i_gun_photodetector;
    logic       i_mouse_on_target;
    logic       o_screen_black;
    logic       o_draw_target_box;
    logic       o_hit;
    logic       o_miss;
    logic [1:0] o_shots_left;
    logic       o_out_of_ammo;
    logic       o_busy;

    int checkCount = 0;
    int passCount  = 0;
    int hitCount   = 0;
    int missCount  = 0;

    shot_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_frame_start       (i_frame_start),
        .i_round_start       (i_round_start),
        .i_gun_is_connected  (i_gun_is_connected),
        .i_trigger_pulse     (i_trigger_pulse),
        .i_gun_photodetector (i_gun_photodetector),
        .i_mouse_on_target   (i_mouse_on_target),
        .o_screen_black      (o_screen_black),
        .o_draw_target_box   (o_draw_target_box),
        .o_hit               (o_hit),
        .o_miss              (o_miss),
        .o_shots_left        (o_shots_left),
        .o_out_of_ammo       (o_out_of_ammo),
        .o_busy              (o_busy)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count result pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (o_hit) hitCount++;
        if (o_miss) missCount++;
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fs();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
    endtask

    // Run frames until busy drops, bounded
    task automatic wait_idle(input string name);
        for (int i = 0; i < 30 && o_busy; i++) begin
            fs();
            step();
            step();
        end
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL %s_idle: busy=%b required 0", name, o_busy);
        else passCount++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checkCount++;
        if ({o_screen_black, o_draw_target_box, o_hit, o_miss, o_busy} !== 5'b0)
            $display("[TB] FAIL reset_outs: black/draw/hit/miss/busy=%b required 00000",
                     {o_screen_black, o_draw_target_box, o_hit, o_miss, o_busy});
        else passCount++;
        checkCount++;
        if (o_shots_left !== 2'd0 || o_out_of_ammo !== 1'b1)
            $display("[TB] FAIL reset_ammo: shots=%0d ooa=%b required 0 1", o_shots_left, o_out_of_ammo);
        else passCount++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_mouse_hit();
        int h0, m0;
        i_round_start = 1'b1;
        step();
        i_round_start = 1'b0;
        checkCount++;
        if (o_shots_left !== 2'd3) $display("[TB] FAIL mouse_reload: shots=%0d required 3", o_shots_left);
        else passCount++;
        repeat (5) step();
        h0 = hitCount; m0 = missCount;
        i_gun_is_connected = 1'b0;
        i_mouse_on_target  = 1'b1;
        i_trigger_pulse    = 1'b1;
        step();
        i_trigger_pulse = 1'b0;
        checkCount++;
        if (o_hit !== 1'b0 || o_busy !== 1'b1 || o_shots_left !== 2'd2)
            $display("[TB] FAIL mouse_n1: hit=%b busy=%b shots=%0d required 0 1 2", o_hit, o_busy, o_shots_left);
        else passCount++;
        step();
        checkCount++;
        if (o_hit !== 1'b1 || o_miss !== 1'b0)
            $display("[TB] FAIL mouse_n2: hit=%b miss=%b required 1 0", o_hit, o_miss);
        else passCount++;
        step();
        checkCount++;
        if (o_hit !== 1'b0) $display("[TB] FAIL mouse_n3: hit=%b required 0", o_hit);
        else passCount++;
        repeat (7) begin
            fs();
            step();
        end
        checkCount++;
        if (o_busy !== 1'b1) $display("[TB] FAIL mouse_cool7: busy=%b required 1", o_busy);
        else passCount++;
        fs();
        checkCount++;
        if (o_busy !== 1'b0) $display("[TB] FAIL mouse_cool8: busy=%b required 0", o_busy);
        else passCount++;
        checkCount++;
        if (hitCount - h0 !== 1 || missCount - m0 !== 0)
            $display("[TB] FAIL mouse_count: hits=%0d misses=%0d required 1 0", hitCount - h0, missCount - m0);
        else passCount++;
        i_mouse_on_target = 1'b0;
    endtask

    task automatic test_gun_hit();
        int h0, m0;
        h0 = hitCount; m0 = missCount;
        i_gun_is_connected  = 1'b1;
        i_gun_photodetector = 1'b0;
        i_trigger_pulse     = 1'b1;
        step();
        i_trigger_pulse = 1'b0;
        checkCount++;
        if (o_busy !== 1'b1 || o_screen_black !== 1'b0)
            $display("[TB] FAIL gun_arm: busy=%b black=%b required 1 0", o_busy, o_screen_black);
        else passCount++;
        step(); step();
        fs();
        checkCount++;
        if (o_screen_black !== 1'b1 || o_draw_target_box !== 1'b0)
            $display("[TB] FAIL gun_blank: black=%b draw=%b required 1 0", o_screen_black, o_draw_target_box);
        else passCount++;
        repeat (3) step();
        fs();
        checkCount++;
        if (o_screen_black !== 1'b1 || o_draw_target_box !== 1'b1)
            $display("[TB] FAIL gun_target: black=%b draw=%b required 1 1", o_screen_black, o_draw_target_box);
        else passCount++;
        i_gun_photodetector = 1'b1;
        repeat (4) step();
        fs();
        checkCount++;
        if (o_hit !== 1'b0 || o_screen_black !== 1'b0 || o_draw_target_box !== 1'b0)
            $display("[TB] FAIL gun_m1: hit=%b black=%b draw=%b required 0 0 0", o_hit, o_screen_black, o_draw_target_box);
        else passCount++;
        step();
        i_gun_photodetector = 1'b0;
        checkCount++;
        if (o_hit !== 1'b1 || o_miss !== 1'b0)
            $display("[TB] FAIL gun_m2: hit=%b miss=%b required 1 0", o_hit, o_miss);
        else passCount++;
        step();
        checkCount++;
        if (o_hit !== 1'b0) $display("[TB] FAIL gun_m3: hit=%b required 0", o_hit);
        else passCount++;
        wait_idle("gun_hit");
        checkCount++;
        if (hitCount - h0 !== 1 || missCount - m0 !== 0 || o_shots_left !== 2'd1)
            $display("[TB] FAIL gun_count: hits=%0d misses=%0d shots=%0d required 1 0 1",
                     hitCount - h0, missCount - m0, o_shots_left);
        else passCount++;
    endtask

    task automatic test_gun_cheat();
        int h0, m0;
        h0 = hitCount; m0 = missCount;
        i_gun_is_connected  = 1'b1;
        i_gun_photodetector = 1'b1;
        repeat (3) step();
        i_trigger_pulse = 1'b1;
        step();
        i_trigger_pulse = 1'b0;
        step();
        fs(); repeat (3) step();
        fs(); repeat (3) step();
        fs();
        step();
        checkCount++;
        if (o_miss !== 1'b1 || o_hit !== 1'b0)
            $display("[TB] FAIL cheat_result: hit=%b miss=%b required 0 1", o_hit, o_miss);
        else passCount++;
        i_gun_photodetector = 1'b0;
        wait_idle("cheat");
        checkCount++;
        if (hitCount - h0 !== 0 || missCount - m0 !== 1 || o_shots_left !== 2'd0 || o_out_of_ammo !== 1'b1)
            $display("[TB] FAIL cheat_count: hits=%0d misses=%0d shots=%0d ooa=%b required 0 1 0 1",
                     hitCount - h0, missCount - m0, o_shots_left, o_out_of_ammo);
        else passCount++;
    endtask

    task automatic test_ammo();
        int r0;
        logic [1:0] expShots [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
        i_round_start = 1'b1;
        step();
        i_round_start = 1'b0;
        r0 = hitCount + missCount;
        i_gun_is_connected = 1'b0;
        i_mouse_on_target  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_trigger_pulse = 1'b1;
            step();
            i_trigger_pulse = 1'b0;
            checkCount++;
            if (o_shots_left !== expShots[i])
                $display("[TB] FAIL ammo_shot%0d: shots=%0d required %0d", i, o_shots_left, expShots[i]);
            else passCount++;
            step(); step();
            wait_idle("ammo");
        end
        checkCount++;
        if (hitCount + missCount - r0 !== 3 || o_out_of_ammo !== 1'b1)
            $display("[TB] FAIL ammo_total: resolutions=%0d ooa=%b required 3 1", hitCount + missCount - r0, o_out_of_ammo);
        else passCount++;
        i_round_start = 1'b1;
        step();
        i_round_start = 1'b0;
        checkCount++;
        if (o_shots_left !== 2'd3 || o_out_of_ammo !== 1'b0)
            $display("[TB] FAIL ammo_reload: shots=%0d ooa=%b required 3 0", o_shots_left, o_out_of_ammo);
        else passCount++;
        i_mouse_on_target = 1'b0;
    endtask

    task automatic test_ignored_triggers();
        int h0, m0;
        h0 = hitCount; m0 = missCount;
        i_gun_is_connected  = 1'b1;
        i_gun_photodetector = 1'b0;
        i_trigger_pulse     = 1'b1;
        step();
        i_trigger_pulse = 1'b0;
        step();
        fs(); step(); step();
        fs();
        i_trigger_pulse    = 1'b1;
        i_gun_is_connected = 1'b0;
        step();
        i_trigger_pulse     = 1'b0;
        i_gun_photodetector = 1'b1;
        repeat (3) step();
        fs();
        step();
        i_gun_photodetector = 1'b0;
        step();
        i_trigger_pulse = 1'b1;
        step();
        i_trigger_pulse = 1'b0;
        wait_idle("ignored");
        checkCount++;
        if (hitCount - h0 !== 1 || missCount - m0 !== 0 || o_shots_left !== 2'd2)
            $display("[TB] FAIL ignored_count: hits=%0d misses=%0d shots=%0d required 1 0 2",
                     hitCount - h0, missCount - m0, o_shots_left);
        else passCount++;
        m0 = missCount;
        i_mouse_on_target = 1'b0;
        i_round_start     = 1'b1;
        i_trigger_pulse   = 1'b1;
        step();
        i_round_start   = 1'b0;
        i_trigger_pulse = 1'b0;
        checkCount++;
        if (o_shots_left !== 2'd2 || o_busy !== 1'b1)
            $display("[TB] FAIL reload_trigger: shots=%0d busy=%b required 2 1", o_shots_left, o_busy);
        else passCount++;
        step(); step();
        wait_idle("reload_trigger");
        checkCount++;
        if (missCount - m0 !== 1) $display("[TB] FAIL reload_trigger_miss: misses=%0d required 1", missCount - m0);
        else passCount++;
    endtask

    task automatic test_reset_mid_target();
        int r0;
        r0 = hitCount + missCount;
        i_gun_is_connected  = 1'b1;
        i_gun_photodetector = 1'b0;
        i_trigger_pulse     = 1'b1;
        step();
        i_trigger_pulse = 1'b0;
        fs(); step();
        fs(); step();
        i_gun_photodetector = 1'b1;
        repeat (3) step();
        checkCount++;
        if (o_draw_target_box !== 1'b1) $display("[TB] FAIL rst_pre: draw=%b required 1", o_draw_target_box);
        else passCount++;
        rst = 1'b1;
        step();
        checkCount++;
        if ({o_screen_black, o_draw_target_box, o_hit, o_miss, o_busy} !== 5'b0 ||
            o_shots_left !== 2'd0 || o_out_of_ammo !== 1'b1)
            $display("[TB] FAIL rst_mid: black/draw/hit/miss/busy=%b shots=%0d ooa=%b required 00000 0 1",
                     {o_screen_black, o_draw_target_box, o_hit, o_miss, o_busy}, o_shots_left, o_out_of_ammo);
        else passCount++;
        rst = 1'b0;
        i_gun_photodetector = 1'b0;
        repeat (12) begin
            fs();
            step();
        end
        checkCount++;
        if (hitCount + missCount - r0 !== 0 || o_busy !== 1'b0)
            $display("[TB] FAIL rst_no_pulse: resolutions=%0d busy=%b required 0 0", hitCount + missCount - r0, o_busy);
        else passCount++;
    endtask

    initial begin
        rst                 = 1'b1;
        i_frame_start       = 1'b0;
        i_round_start       = 1'b0;
        i_gun_is_connected  = 1'b0;
        i_trigger_pulse     = 1'b0;
        i_gun_photodetector = 1'b0;
        i_mouse_on_target   = 1'b0;
        test_reset();
        test_mouse_hit();
        test_gun_hit();
        test_gun_cheat();
        test_ammo();
        test_ignored_triggers();
        test_reset_mid_target();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
